matrix_proc_if: RTL and testbench

MATRIX_PROC_IF -- requirements
Module: matrix_proc_if

---
 rtl/matrix_pkg.sv | 32 +++
 rtl/flex_counter.sv | 39 +++
 rtl/matrix_proc_if.sv | 200 ++++++++++++++++++++
 tb/tb_matrix_proc_if.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared register map, CTRL bit positions, fill FSM states and panel defaults.
// No logic; constants and types only.
// Imported by the matrix processor interface and its bench-facing users.
package matrix_pkg;

    localparam int DEF_MATRIX_WIDTH  = 64;
    localparam int DEF_MATRIX_HEIGHT = 32;

    localparam logic [7:0] REG_CTRL  = 8'd0;
    localparam logic [7:0] REG_ROW   = 8'd1;
    localparam logic [7:0] REG_COL   = 8'd2;
    localparam logic [7:0] REG_RED   = 8'd3;
    localparam logic [7:0] REG_GRN   = 8'd4;
    localparam logic [7:0] REG_BLU   = 8'd5;
    localparam logic [7:0] REG_COUNT = 8'd6;

    localparam int CTRL_AUTOINC = 0;
    localparam int CTRL_FILL    = 1;
    localparam int CTRL_BUSY    = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

    typedef struct packed {
        logic [7:0] blu;
        logic [7:0] grn;
        logic [7:0] red;
    } pixel_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear, enable and programmable rollover value.
// Count updates one cycle after enable; rollover_flag is combinational on the count.
// No backpressure; counts whenever enabled.
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count_q == rollover_val) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/matrix_proc_if.sv
// Bus-mapped pixel writer for an LED matrix colour memory, with single-pixel commit and full-panel fill.
// Reads are combinational; a BLU commit writes memory one cycle later; a fill writes one pixel per cycle.
// No backpressure: commits and fill requests arriving while busy are dropped.
module matrix_proc_if
    import matrix_pkg::*;
#(
    parameter int         MATRIX_WIDTH  = DEF_MATRIX_WIDTH,
    parameter int         MATRIX_HEIGHT = DEF_MATRIX_HEIGHT,
    parameter int         DATA_WIDTH    = 8,
    parameter int         ROW_LENGTH    = 7,
    parameter int         COLUMN_LENGTH = 6,
    parameter logic [7:0] BASE_ADDR     = 8'hE0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                ramadr,
    input  logic                      ramre,
    input  logic                      ramwe,
    input  logic                      dm_sel,
    input  logic [7:0]                dbus_in,
    output logic [7:0]                dbus_out,
    output logic                      io_out_en,
    output logic [ROW_LENGTH-1:0]     proc_ctrl_row,
    output logic [COLUMN_LENGTH-1:0]  proc_ctrl_col,
    output logic                      proc_ctrl_we,
    output logic [3*DATA_WIDTH-1:0]   proc_ctrl_data_o,
    output logic                      busy
);

    localparam int NPIX  = MATRIX_WIDTH * MATRIX_HEIGHT;
    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    logic [7:0] reg_off;
    logic       wr_hit;
    logic       rd_hit;

    assign reg_off = ramadr - BASE_ADDR;
    assign wr_hit  = dm_sel && ramwe && (reg_off < REG_COUNT);
    assign rd_hit  = dm_sel && ramre && (reg_off < REG_COUNT);

    fill_state_e state_q, state_d;
    logic        autoinc_q, autoinc_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  col_q, col_d;
    logic [7:0]  red_q, red_d;
    logic [7:0]  grn_q, grn_d;
    logic [7:0]  blu_q, blu_d;
    pixel_t      fill_rgb_q, fill_rgb_d;
    logic        busy_q, busy_d;
    logic        we_q, we_d;
    logic [ROW_LENGTH-1:0]    out_row_q, out_row_d;
    logic [COLUMN_LENGTH-1:0] out_col_q, out_col_d;
    logic [3*DATA_WIDTH-1:0]  out_data_q, out_data_d;

    logic             cnt_clear;
    logic             cnt_en;
    logic             cnt_last;
    logic [CNT_W-1:0] pix_cnt;

    flex_counter #(
        .WIDTH(CNT_W)
    ) u_pix_cnt (
        .clk          (clk),
        .rst          (rst),
        .clear        (cnt_clear),
        .count_enable (cnt_en),
        .rollover_val (CNT_W'(NPIX - 1)),
        .count_out    (pix_cnt),
        .rollover_flag(cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        autoinc_d  = autoinc_q;
        row_d      = row_q;
        col_d      = col_q;
        red_d      = red_q;
        grn_d      = grn_q;
        blu_d      = blu_q;
        fill_rgb_d = fill_rgb_q;
        we_d       = 1'b0;
        out_row_d  = out_row_q;
        out_col_d  = out_col_q;
        out_data_d = out_data_q;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;

        // Single-pixel commit: coordinates are those held when BLU is written.
        if (wr_hit && reg_off == REG_BLU && !busy_q) begin
            we_d       = 1'b1;
            out_row_d  = ROW_LENGTH'(row_q);
            out_col_d  = COLUMN_LENGTH'(col_q);
            out_data_d = {dbus_in, grn_q, red_q};
            if (autoinc_q) begin
                if (col_q == 8'(MATRIX_WIDTH - 1)) begin
                    col_d = '0;
                    row_d = (row_q == 8'(MATRIX_HEIGHT - 1)) ? 8'd0 : row_q + 8'd1;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
        end

        // Register writes come after auto-increment so a ROW/COL write wins.
        if (wr_hit) begin
            case (reg_off)
                REG_CTRL: autoinc_d = dbus_in[CTRL_AUTOINC];
                REG_ROW:  row_d     = dbus_in;
                REG_COL:  col_d     = dbus_in;
                REG_RED:  red_d     = dbus_in;
                REG_GRN:  grn_d     = dbus_in;
                REG_BLU:  blu_d     = dbus_in;
                default:  ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_hit && reg_off == REG_CTRL && dbus_in[CTRL_FILL] && !busy_q) begin
                    state_d    = ST_FILL;
                    fill_rgb_d = '{blu: blu_q, grn: grn_q, red: red_q};
                    cnt_clear  = 1'b1;
                end
            end
            ST_FILL: begin
                cnt_en     = 1'b1;
                we_d       = 1'b1;
                out_row_d  = ROW_LENGTH'(int'(pix_cnt) / MATRIX_WIDTH);
                out_col_d  = COLUMN_LENGTH'(int'(pix_cnt) % MATRIX_WIDTH);
                out_data_d = fill_rgb_q;
                if (cnt_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Busy stays up through the cycle that presents the last fill pixel.
        busy_d = (state_d == ST_FILL) || (state_q == ST_FILL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            autoinc_q  <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            red_q      <= '0;
            grn_q      <= '0;
            blu_q      <= '0;
            fill_rgb_q <= '0;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            out_row_q  <= '0;
            out_col_q  <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            autoinc_q  <= autoinc_d;
            row_q      <= row_d;
            col_q      <= col_d;
            red_q      <= red_d;
            grn_q      <= grn_d;
            blu_q      <= blu_d;
            fill_rgb_q <= fill_rgb_d;
            busy_q     <= busy_d;
            we_q       <= we_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        dbus_out  = '0;
        io_out_en = 1'b0;
        if (rd_hit) begin
            io_out_en = 1'b1;
            case (reg_off)
                REG_CTRL: begin
                    dbus_out[CTRL_AUTOINC] = autoinc_q;
                    dbus_out[CTRL_BUSY]    = busy_q;
                end
                REG_ROW: dbus_out = row_q;
                REG_COL: dbus_out = col_q;
                REG_RED: dbus_out = red_q;
                REG_GRN: dbus_out = grn_q;
                REG_BLU: dbus_out = blu_q;
                default: dbus_out = '0;
            endcase
        end
    end

    assign proc_ctrl_row    = out_row_q;
    assign proc_ctrl_col    = out_col_q;
    assign proc_ctrl_we     = we_q;
    assign proc_ctrl_data_o = out_data_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_matrix_proc_if.sv
// Randomized register traffic plus directed commit, wrap, fill and reset scenarios for matrix_proc_if,
// checked against a queue of expected memory writes and a register-level reference model.
module tb_matrix_proc_if;

    localparam int         W    = 64;
    localparam int         H    = 32;
    localparam int         N    = W * H;
    localparam logic [7:0] BASE = 8'hE0;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ramadr;
    logic        ramre;
    logic        ramwe;
    logic        dm_sel;
    logic [7:0]  dbus_in;
    logic [7:0]  dbus_out;
    logic        io_out_en;
    logic [6:0]  proc_ctrl_row;
    logic [5:0]  proc_ctrl_col;
    logic        proc_ctrl_we;
    logic [23:0] proc_ctrl_data_o;
    logic        busy;

    always #5 clk = ~clk;

    matrix_proc_if dut (
        .clk             (clk),
        .rst             (rst),
        .ramadr          (ramadr),
        .ramre           (ramre),
        .ramwe           (ramwe),
        .dm_sel          (dm_sel),
        .dbus_in         (dbus_in),
        .dbus_out        (dbus_out),
        .io_out_en       (io_out_en),
        .proc_ctrl_row   (proc_ctrl_row),
        .proc_ctrl_col   (proc_ctrl_col),
        .proc_ctrl_we    (proc_ctrl_we),
        .proc_ctrl_data_o(proc_ctrl_data_o),
        .busy            (busy)
    );

    typedef logic [36:0] exp_t;   // {row[6:0], col[5:0], {blu,grn,red}}
    exp_t exp_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int we_cnt   = 0;
    int run_len  = 0;
    int last_run = 0;

    logic [7:0] m_row, m_col, m_red, m_grn, m_blu;
    logic       m_auto, m_busy;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every memory write must match the next expected write, in order.
    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
        end else if (proc_ctrl_we) begin
            we_cnt++;
            run_len++;
            if (exp_q.size() == 0)
                check_val("unexpected_we", proc_ctrl_we, 1'b0);
            else
                check_val("we_pixel", {proc_ctrl_row, proc_ctrl_col, proc_ctrl_data_o}, exp_q.pop_front());
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    task automatic model_reset();
        m_row = 0; m_col = 0; m_red = 0; m_grn = 0; m_blu = 0;
        m_auto = 1'b0; m_busy = 1'b0;
    endtask

    function automatic logic [8:0] model_read(input logic [7:0] a, input logic sel);
        logic [7:0] off;
        off = a - BASE;
        if (!sel || off >= 8'd6) return 9'h000;
        case (off)
            8'd0:    return {1'b1, m_busy, 6'b0, m_auto};
            8'd1:    return {1'b1, m_row};
            8'd2:    return {1'b1, m_col};
            8'd3:    return {1'b1, m_red};
            8'd4:    return {1'b1, m_grn};
            default: return {1'b1, m_blu};
        endcase
    endfunction

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input logic sel);
        @(negedge clk);
        ramadr = a; dbus_in = d; dm_sel = sel; ramwe = 1'b1;
        @(negedge clk);
        ramwe = 1'b0; dm_sel = 1'b0;
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d, input logic sel);
        logic [7:0] off;
        off = a - BASE;
        if (sel && off < 8'd6) begin
            case (off)
                8'd0: begin
                    if (d[1] && !m_busy) begin
                        for (int i = 0; i < N; i++)
                            exp_q.push_back({7'(i / W), 6'(i % W), m_blu, m_grn, m_red});
                        m_busy = 1'b1;
                    end
                    m_auto = d[0];
                end
                8'd1: m_row = d;
                8'd2: m_col = d;
                8'd3: m_red = d;
                8'd4: m_grn = d;
                default: begin
                    m_blu = d;
                    if (!m_busy) begin
                        exp_q.push_back({m_row[6:0], m_col[5:0], d, m_grn, m_red});
                        if (m_auto) begin
                            if (m_col == 8'(W - 1)) begin
                                m_col = 0;
                                m_row = (m_row == 8'(H - 1)) ? 8'd0 : m_row + 8'd1;
                            end else begin
                                m_col = m_col + 8'd1;
                            end
                        end
                    end
                end
            endcase
        end
        bus_write(a, d, sel);
    endtask

    task automatic check_read(input string tag, input logic [7:0] a, input logic sel);
        @(negedge clk);
        ramadr = a; dm_sel = sel; ramre = 1'b1;
        #1;
        check_val(tag, {io_out_en, dbus_out}, model_read(a, sel));
        ramre = 1'b0; dm_sel = 1'b0;
    endtask

    task automatic wait_we(input int target, input int budget);
        int b;
        b = budget;
        while (we_cnt < target && b > 0) begin
            @(negedge clk);
            b--;
        end
        check_val("wait_we_reached", 64'(we_cnt >= target), 64'd1);
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        check_val("drain_left", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        #1;
        m_busy = 1'b0;
        check_val("busy_after_fill", busy, 1'b0);
    endtask

    initial begin
        int base;
        logic [7:0] d;
        rst = 1'b1; ramadr = 0; ramre = 0; ramwe = 0; dm_sel = 0; dbus_in = 0;
        model_reset();
        #1;
        check_val("reset_outputs", {proc_ctrl_we, busy, proc_ctrl_row, proc_ctrl_col, proc_ctrl_data_o}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) check_read("reset_reg", BASE + 8'(i), 1'b1);

        // Basic commit: one pulse, next cycle, coordinates held at BLU write.
        reg_write(BASE + 8'd1, 8'd3, 1'b1);
        reg_write(BASE + 8'd2, 8'd5, 1'b1);
        reg_write(BASE + 8'd3, 8'h11, 1'b1);
        reg_write(BASE + 8'd4, 8'h22, 1'b1);
        reg_write(BASE + 8'd5, 8'h33, 1'b1);
        #1;
        check_val("commit_we_next", {proc_ctrl_we, proc_ctrl_row, proc_ctrl_col, proc_ctrl_data_o},
                  {1'b1, 7'd3, 6'd5, 24'h332211});
        @(negedge clk);
        #1;
        check_val("commit_one_pulse", proc_ctrl_we, 1'b0);

        // Auto-increment wrap at the bottom-right corner.
        reg_write(BASE + 8'd0, 8'h01, 1'b1);
        reg_write(BASE + 8'd1, 8'd31, 1'b1);
        reg_write(BASE + 8'd2, 8'd63, 1'b1);
        reg_write(BASE + 8'd5, 8'h44, 1'b1);
        check_read("wrap_row", BASE + 8'd1, 1'b1);
        check_read("wrap_col", BASE + 8'd2, 1'b1);
        check_read("wrap_ctrl", BASE + 8'd0, 1'b1);

        // Decode boundaries.
        check_read("addr_plus6", BASE + 8'd6, 1'b1);
        check_read("no_dm_sel", BASE + 8'd1, 1'b0);
        check_read("addr_below", BASE - 8'd1, 1'b1);

        // Random register traffic and commits.
        for (int it = 0; it < 80; it++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1: reg_write(BASE + 8'd1, ($urandom_range(0, 7) == 0) ? d : 8'($urandom_range(0, H - 1)), 1'b1);
                2, 3: reg_write(BASE + 8'd2, ($urandom_range(0, 7) == 0) ? d : 8'($urandom_range(W - 4, W - 1)), 1'b1);
                4:    reg_write(BASE + 8'($urandom_range(3, 4)), d, 1'($urandom_range(0, 1)));
                5:    reg_write(BASE, d & 8'hFD, 1'b1);
                6, 7: reg_write(BASE + 8'd5, d, 1'b1);
                8:    check_read("rand_reg", BASE + 8'($urandom_range(0, 5)), 1'b1);
                default: check_read("rand_addr", BASE - 8'd2 + 8'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
            endcase
        end
        repeat (2) @(negedge clk);
        check_val("rand_drained", 64'(exp_q.size()), 64'd0);

        // Full fill.
        reg_write(BASE + 8'd3, 8'hFF, 1'b1);
        reg_write(BASE + 8'd4, 8'h00, 1'b1);
        reg_write(BASE + 8'd5, 8'h80, 1'b1);
        repeat (2) @(negedge clk);
        reg_write(BASE + 8'd0, 8'h02, 1'b1);
        #1;
        check_val("fill_busy_start", {busy, proc_ctrl_we}, 2'b10);
        base = we_cnt;
        wait_we(base + 1000, 3000);
        check_read("fill_ctrl_busy", BASE, 1'b1);
        check_val("fill_busy_port", busy, 1'b1);
        wait_drain(3000);
        check_val("fill_len", 64'(last_run), 64'(N));
        check_read("fill_ctrl_done", BASE, 1'b1);

        // BLU and ROW writes during a fill change registers only.
        reg_write(BASE + 8'd3, 8'h12, 1'b1);
        reg_write(BASE + 8'd0, 8'h02, 1'b1);
        base = we_cnt;
        wait_we(base + 100, 500);
        reg_write(BASE + 8'd5, 8'h55, 1'b1);
        reg_write(BASE + 8'd1, 8'd7, 1'b1);
        reg_write(BASE + 8'd0, 8'h03, 1'b1);
        wait_drain(3000);
        check_val("fill2_len", 64'(last_run), 64'(N));
        check_read("fill2_blu", BASE + 8'd5, 1'b1);
        check_read("fill2_row", BASE + 8'd1, 1'b1);
        check_read("fill2_ctrl", BASE, 1'b1);

        // Reset in the middle of a fill.
        reg_write(BASE + 8'd0, 8'h02, 1'b1);
        base = we_cnt;
        wait_we(base + 500, 1000);
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_outputs", {proc_ctrl_we, busy, proc_ctrl_row, proc_ctrl_col, proc_ctrl_data_o}, 64'd0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) check_read("rst_reg", BASE + 8'(i), 1'b1);
        repeat (20) @(negedge clk);
        #1;
        check_val("rst_no_resume", {busy, proc_ctrl_we}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
